// File: rtl/trn_tx_arb_pkg.sv
// trn_tx_arb_pkg
//   Shared definitions for the TRN tx arbiter.
//   - arb_state_e : arbiter FSM state encodings (IDLE/GRANT/BUSY/GAP)
//   - TAG_W       : width of the shared non-posted TLP tag counter
//   - ERR_*       : bit positions of the sticky arb_err cause register
package trn_tx_arb_pkg;

    localparam int TAG_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BUSY  = 2'd2,
        ST_GAP   = 2'd3
    } arb_state_e;

    localparam int ERR_W   = 3;
    localparam int ERR_DRV = 0;  // drv_ep from a requester that does not own the bus
    localparam int ERR_TAG = 1;  // tag_inc from a requester that does not own the bus
    localparam int ERR_TMO = 2;  // grant revoked because drv_ep never came

endpackage

// File: rtl/trn_tx_arb_rr_pick.sv
// trn_tx_arb_rr_pick
//   Combinational round-robin priority encoder: returns the first set request
//   bit at or after ptr, wrapping past NREQ-1 back to 0.
// Ports
//   req  in  NREQ   request vector
//   ptr  in  IDX_W  highest-priority index
//   gnt  out NREQ   one-hot selected request (zero when none)
//   idx  out IDX_W  index of the selected request
//   any  out 1      at least one request set
module trn_tx_arb_rr_pick
    import trn_tx_arb_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int unsigned j;

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                idx    = IDX_W'(j);
                gnt[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trn_tx_arb.sv
// trn_tx_arb
//   Shares the PCIe endpoint TRN tx interface between NREQ requesters with a
//   round-robin grant (my_trn/req_ep/drv_ep handshake) and owns the shared
//   5-bit non-posted TLP tag counter. Runs in the pcie_clk domain.
// Optional feature macro: TRN_ARB_TIMEOUT_EN
//   When defined, a grant that is not answered by drv_ep within TIMEOUT
//   cycles is revoked and flagged in arb_err. When undefined, GRANT waits
//   indefinitely and no timeout counter exists.
// Ports
//   clk       in   1      pcie_clk
//   rst       in   1      asynchronous, active-high reset
//   req_ep    in   NREQ   per-requester request, held until transfer done
//   drv_ep    in   NREQ   per-requester "driving TRN tx" flag
//   tag_inc   in   NREQ   per-requester one-cycle pulse: one tag consumed
//   my_trn    out  NREQ   registered grant, one-hot or zero
//   tag_trn   out  TAG_W  current free tag
//   arb_busy  out  1      FSM not in IDLE
//   arb_err   out  1      sticky protocol error, cleared only by rst
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; pick next requester round-robin from ptr
// ST_GRANT | my_trn[g] high, waiting for drv_ep[g] (or withdrawal)
// ST_BUSY  | requester g is driving TRN tx
// ST_GAP   | one-cycle bus turnaround, my_trn=0, ptr moves past g
module trn_tx_arb
    import trn_tx_arb_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NREQ-1:0]  req_ep,
    input  logic [NREQ-1:0]  drv_ep,
    input  logic [NREQ-1:0]  tag_inc,
    output logic [NREQ-1:0]  my_trn,
    output logic [TAG_W-1:0] tag_trn,
    output logic             arb_busy,
    output logic             arb_err
);

    localparam int IDX_W = $clog2(NREQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [NREQ-1:0]  my_trn_q, my_trn_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ERR_W-1:0] err_q, err_d;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             tmo_hit;

    trn_tx_arb_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req (req_ep),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

`ifdef TRN_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Down-counter loaded on grant; terminal count in GRANT revokes the grant,
    // giving exactly TIMEOUT cycles of my_trn high without drv_ep.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ST_IDLE && pick_any) begin
            tmo_d = TMO_W'(TIMEOUT - 1);
        end else if (state_q == ST_GRANT && tmo_q != '0) begin
            tmo_d = tmo_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign tmo_hit = (tmo_q == '0);
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        g_d      = g_q;
        my_trn_d = my_trn_q;
        tag_d    = tag_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    g_d      = pick_idx;
                    my_trn_d = pick_gnt;
                    state_d  = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (drv_ep[g_q]) begin
                    state_d = ST_BUSY;
                end else if (!req_ep[g_q]) begin
                    state_d  = ST_GAP;
                    my_trn_d = '0;
                end else if (tmo_hit) begin
                    state_d        = ST_GAP;
                    my_trn_d       = '0;
                    err_d[ERR_TMO] = 1'b1;
                end
            end
            ST_BUSY: begin
                if (!drv_ep[g_q]) begin
                    state_d  = ST_GAP;
                    my_trn_d = '0;
                end
            end
            ST_GAP: begin
                ptr_d   = (g_q == IDX_W'(NREQ - 1)) ? '0 : g_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                my_trn_d = '0;
            end
        endcase

        // my_trn_q is the owner mask: one-hot in GRANT/BUSY (which includes
        // the cycle drv_ep falls), zero in IDLE/GAP. Anything outside it is
        // a protocol error.
        if (|(tag_inc & my_trn_q)) begin
            tag_d = tag_q + 1'b1;
        end
        if (|(tag_inc & ~my_trn_q)) begin
            err_d[ERR_TAG] = 1'b1;
        end
        if (|(drv_ep & ~my_trn_q)) begin
            err_d[ERR_DRV] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            g_q      <= '0;
            my_trn_q <= '0;
            tag_q    <= '0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            g_q      <= g_d;
            my_trn_q <= my_trn_d;
            tag_q    <= tag_d;
            err_q    <= err_d;
        end
    end

    assign my_trn   = my_trn_q;
    assign tag_trn  = tag_q;
    assign arb_busy = (state_q != ST_IDLE);
    assign arb_err  = |err_q;

endmodule

// File: tb/tb_trn_tx_arb.sv
module tb_trn_tx_arb;

    localparam int NREQ    = 2;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NREQ-1:0] req_ep;
    logic [NREQ-1:0] drv_ep;
    logic [NREQ-1:0] tag_inc;
    logic [NREQ-1:0] my_trn;
    logic [4:0]      tag_trn;
    logic            arb_busy;
    logic            arb_err;

    int n_chk  = 0;
    int n_fail = 0;

    trn_tx_arb #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_ep   (req_ep),
        .drv_ep   (drv_ep),
        .tag_inc  (tag_inc),
        .my_trn   (my_trn),
        .tag_trn  (tag_trn),
        .arb_busy (arb_busy),
        .arb_err  (arb_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        req_ep  = '0;
        drv_ep  = '0;
        tag_inc = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (my_trn != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    logic ok;

    initial begin
        // reset values, checked before any clock edge
        rst     = 1'b1;
        req_ep  = '0;
        drv_ep  = '0;
        tag_inc = '0;
        #3;
        check("rst_my_trn", 32'(my_trn), 32'h0);
        check("rst_tag", 32'(tag_trn), 32'h0);
        check("rst_busy", 32'(arb_busy), 32'h0);
        check("rst_err", 32'(arb_err), 32'h0);
        tick();
        rst = 1'b0;

        // 1: single request, 10-cycle drive, one-cycle gap
        req_ep = 2'b01;
        tick();
        check("t1_grant", 32'(my_trn), 32'h1);
        check("t1_busy", 32'(arb_busy), 32'h1);
        drv_ep = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t1_hold", 32'(my_trn), 32'h1);
        end
        drv_ep = 2'b00;
        req_ep = 2'b00;
        tick();
        check("t1_gap_trn", 32'(my_trn), 32'h0);
        check("t1_gap_busy", 32'(arb_busy), 32'h1);
        tick();
        check("t1_idle_busy", 32'(arb_busy), 32'h0);
        check("t1_idle_trn", 32'(my_trn), 32'h0);
        check("t1_err", 32'(arb_err), 32'h0);

        // 2: both requesters held, grants alternate
        do_reset();
        req_ep = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_grant(5, ok);
            check("t2_grant_wait", 32'(ok), 32'h1);
            check("t2_grant", 32'(my_trn), (k % 2 == 0) ? 32'h1 : 32'h2);
            drv_ep = my_trn;
            for (int i = 0; i < 4; i++) tick();
            drv_ep = 2'b00;
            tick();
            check("t2_gap", 32'(my_trn), 32'h0);
        end
        check("t2_err", 32'(arb_err), 32'h0);

        // drv_ep with nobody granted sets arb_err, no grant appears
        do_reset();
        drv_ep = 2'b01;
        tick();
        drv_ep = 2'b00;
        check("idle_drv_err", 32'(arb_err), 32'h1);
        check("idle_drv_trn", 32'(my_trn), 32'h0);

        // 3: tag counting and wrap, foreign tag_inc ignored
        do_reset();
        req_ep = 2'b01;
        tick();
        drv_ep = 2'b01;
        tick();
        for (int i = 0; i < 33; i++) begin
            tag_inc = 2'b01;
            tick();
            check("t3_tag", 32'(tag_trn), 32'((i + 1) % 32));
        end
        tag_inc = 2'b00;
        check("t3_err0", 32'(arb_err), 32'h0);
        tag_inc = 2'b10;
        tick();
        tag_inc = 2'b00;
        tick();
        check("t3_foreign_tag", 32'(tag_trn), 32'h1);
        check("t3_foreign_err", 32'(arb_err), 32'h1);
        drv_ep = 2'b00;
        req_ep = 2'b00;
        tick();

        // 4: tag_inc on the cycle drv_ep falls, then grant moves on
        do_reset();
        req_ep = 2'b11;
        tick();
        check("t4_grant0", 32'(my_trn), 32'h1);
        drv_ep = 2'b01;
        tick();
        tick();
        drv_ep  = 2'b00;
        tag_inc = 2'b01;
        req_ep  = 2'b10;
        tick();
        tag_inc = 2'b00;
        check("t4_tag", 32'(tag_trn), 32'h1);
        check("t4_gap", 32'(my_trn), 32'h0);
        tick();
        tick();
        check("t4_grant1", 32'(my_trn), 32'h2);
        check("t4_err", 32'(arb_err), 32'h0);

        // 5: foreign drv_ep sets arb_err; async reset mid-BUSY with tag=7
        drv_ep = 2'b10;
        tick();
        for (int i = 0; i < 6; i++) begin
            tag_inc = 2'b10;
            tick();
        end
        tag_inc = 2'b00;
        check("t5_tag7", 32'(tag_trn), 32'h7);
        drv_ep = 2'b11;
        tick();
        check("t5_drv_err", 32'(arb_err), 32'h1);
        check("t5_grant_kept", 32'(my_trn), 32'h2);
        drv_ep = 2'b10;
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_trn", 32'(my_trn), 32'h0);
        check("t5_rst_tag", 32'(tag_trn), 32'h0);
        check("t5_rst_err", 32'(arb_err), 32'h0);
        check("t5_rst_busy", 32'(arb_busy), 32'h0);
        req_ep = '0;
        drv_ep = '0;
        tick();
        rst = 1'b0;
        tick();
        check("t5_post_rst", 32'(my_trn), 32'h0);

`ifdef TRN_ARB_TIMEOUT_EN
        // 6: unanswered grant revoked after TIMEOUT cycles
        do_reset();
        req_ep = 2'b11;
        tick();
        check("t6_grant0", 32'(my_trn), 32'h1);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        check("t6_hold", 32'(my_trn), 32'h1);
        check("t6_err0", 32'(arb_err), 32'h0);
        tick();
        check("t6_revoke", 32'(my_trn), 32'h0);
        check("t6_err", 32'(arb_err), 32'h1);
        tick();
        tick();
        check("t6_next", 32'(my_trn), 32'h2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
